// File: rtl/life_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : life_tracker
//  Purpose  : Tracks the remaining lives in a game. A raw, bouncy hit input is
//             synchronised and debounced. Each accepted hit costs one life and
//             sends a fixed-length active-low pulse to the beeper stage. The
//             design flags game over once the last life is gone.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             hit_in       - raw hit sensor, active-high, asynchronous
//             restart      - synchronous active-high new-game request
//             lives        - remaining lives (registered)
//             life_change  - active-low per-hit notification (registered)
//             game_over    - high while no lives remain (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module life_tracker #(
    parameter int INIT_LIVES      = 3,
    parameter int LIFE_W          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit_in,
    input  logic              restart,
    output logic [LIFE_W-1:0] lives,
    output logic              life_change,
    output logic              game_over
);

    // Counters are wide enough to hold their full parameter value.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [LIFE_W-1:0] C_INIT_LIVES = LIFE_W'(INIT_LIVES);
    localparam logic [DB_W-1:0]   C_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0]   C_PC_LAST    = PC_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        PULSE = 2'd1,
        OVER  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_sync_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= hit_in;
            r_sync      <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce filter. The filtered level flips on the DEBOUNCE_CYCLES-th
    // consecutive cycle of disagreement. Any agreeing cycle restarts the
    // count. This path runs regardless of game state.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] r_db_cnt;
    logic            r_filt;
    logic            r_filt_d;
    logic            w_hit_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync != r_filt) begin
            if (r_db_cnt == C_DB_LAST) begin
                r_filt   <= r_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
        end
    end

    // A single-cycle event on each rising edge of the filtered level.
    // Because the filter resets low, a hit held through reset still
    // yields one event.
    assign w_hit_evt = r_filt & ~r_filt_d;

    // ------------------------------------------------------------------
    // Game FSM: state register and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pcnt;
    logic [PC_W-1:0]   w_pcnt_nxt;
    logic [LIFE_W-1:0] w_lives_nxt;
    logic              w_life_change_nxt;
    logic              w_game_over_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLAY;
            r_pcnt      <= '0;
            lives       <= C_INIT_LIVES;
            life_change <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pcnt      <= w_pcnt_nxt;
            lives       <= w_lives_nxt;
            life_change <= w_life_change_nxt;
            game_over   <= w_game_over_nxt;
        end
    end

    // Next-state logic. Restart has top priority and also swallows any hit
    // event in the same cycle. Hit events that arrive outside PLAY are
    // dropped because only PLAY looks at them.
    always_comb begin
        w_state_nxt       = r_state;
        w_pcnt_nxt        = r_pcnt;
        w_lives_nxt       = lives;
        w_life_change_nxt = life_change;
        w_game_over_nxt   = game_over;

        if (restart) begin
            w_state_nxt       = PLAY;
            w_pcnt_nxt        = '0;
            w_lives_nxt       = C_INIT_LIVES;
            w_life_change_nxt = 1'b1;
            w_game_over_nxt   = 1'b0;
        end else begin
            case (r_state)
                PLAY: begin
                    // Guard against a zero count keeps lives from wrapping.
                    if (w_hit_evt && (lives != '0)) begin
                        w_lives_nxt       = lives - LIFE_W'(1);
                        w_life_change_nxt = 1'b0;
                        w_pcnt_nxt        = '0;
                        w_state_nxt       = PULSE;
                    end
                end
                PULSE: begin
                    // The counter reaches C_PC_LAST on the last low cycle,
                    // so life_change is low for exactly PULSE_CYCLES cycles.
                    if (r_pcnt == C_PC_LAST) begin
                        w_pcnt_nxt        = '0;
                        w_life_change_nxt = 1'b1;
                        if (lives == '0) begin
                            w_state_nxt     = OVER;
                            w_game_over_nxt = 1'b1;
                        end else begin
                            w_state_nxt = PLAY;
                        end
                    end else begin
                        w_pcnt_nxt = r_pcnt + PC_W'(1);
                    end
                end
                OVER: begin
                    w_game_over_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = PLAY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_tracker
//  Purpose  : Self-checking bench for life_tracker. A hit pattern table and a
//             set of hand-written restart/reset sequences drive the design.
//             Expected hit outcomes are queued when stimulus is driven. They
//             are popped and compared when life_change pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_life_tracker;

    localparam int LW   = 3;
    localparam int INIT = 3;
    localparam int DB   = 4;
    localparam int PC   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hit_in;
    logic          restart;
    logic [LW-1:0] lives;
    logic          life_change;
    logic          game_over;

    always #5 clk = ~clk;

    life_tracker #(
        .INIT_LIVES      (INIT),
        .LIFE_W          (LW),
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hit_in      (hit_in),
        .restart     (restart),
        .lives       (lives),
        .life_change (life_change),
        .game_over   (game_over)
    );

    typedef struct {
        int lives;
        int go;
    } exp_t;

    typedef struct {
        string name;
        int    hi;
        int    lo;
        int    reps;
        int    exp_events;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t cur;
    int   m_lives;
    bit   prev_lc   = 1'b1;
    bit   in_pulse  = 1'b0;
    bit   trunc     = 1'b0;
    int   pulse_len = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and track the life_change pulse.
    task automatic step();
        @(negedge clk);
        if (prev_lc && !life_change) begin
            check("pulse_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
            end else begin
                cur.lives = -1;
                cur.go    = 0;
            end
            check("lives_on_hit", int'(lives), cur.lives);
            check("game_over_at_fall", int'(game_over), 0);
            in_pulse  = 1'b1;
            pulse_len = 1;
        end else if (!prev_lc && !life_change) begin
            pulse_len++;
            check("game_over_in_pulse", int'(game_over), 0);
        end else if (!prev_lc && life_change) begin
            in_pulse = 1'b0;
            if (trunc) begin
                trunc = 1'b0;
            end else begin
                check("pulse_len", pulse_len, PC);
                check("game_over_at_rise", int'(game_over), cur.go);
            end
        end
        prev_lc = life_change;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_hit();
        m_lives--;
        sb.push_back('{m_lives, (m_lives == 0) ? 1 : 0});
    endtask

    task automatic wait_pulse(input string name);
        for (int k = 0; k < 30 && !in_pulse; k++) step();
        check(name, int'(in_pulse), 1);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_lives"}, int'(lives), m_lives);
        check({tag, "_game_over"}, int'(game_over), (m_lives == 0) ? 1 : 0);
        check({tag, "_life_change"}, int'(life_change), 1);
        check({tag, "_pending"}, sb.size(), 0);
    endtask

    vec_t vt[6];

    initial begin
        // Patterns run from a fresh reset; lives go 3,3,3,2,1,0,0.
        vt[0] = '{"bounce",      2,  2, 8, 0};
        vt[1] = '{"glitch3",     3, 10, 2, 0};
        vt[2] = '{"exact4",      4, 20, 1, 1};
        vt[3] = '{"clean20",    20, 20, 1, 1};
        vt[4] = '{"double",      4,  4, 2, 1};
        vt[5] = '{"over_hit",   20, 20, 1, 0};

        rst_n   = 1'b0;
        hit_in  = 1'b0;
        restart = 1'b0;
        m_lives = INIT;
        idle(3);
        check("rst_lives", int'(lives), INIT);
        check("rst_life_change", int'(life_change), 1);
        check("rst_game_over", int'(game_over), 0);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            for (int e = 0; e < vt[i].exp_events; e++) push_hit();
            for (int r = 0; r < vt[i].reps; r++) begin
                hit_in = 1'b1;
                idle(vt[i].hi);
                hit_in = 1'b0;
                idle(vt[i].lo);
            end
            idle(12);
            end_checks(vt[i].name);
        end

        // Restart out of OVER.
        restart = 1'b1;
        step();
        restart = 1'b0;
        m_lives = INIT;
        check("restart_over_lives", int'(lives), INIT);
        check("restart_over_game_over", int'(game_over), 0);
        check("restart_over_life_change", int'(life_change), 1);

        push_hit();
        hit_in = 1'b1;
        idle(20);
        hit_in = 1'b0;
        idle(20);
        end_checks("hit_a");

        // Restart in cycle 3 of a pulse with lives=1 truncates the pulse.
        push_hit();
        hit_in = 1'b1;
        wait_pulse("pulse_b_seen");
        idle(2);
        restart = 1'b1;
        trunc   = 1'b1;
        step();
        restart = 1'b0;
        m_lives = INIT;
        check("trunc_lives", int'(lives), INIT);
        check("trunc_life_change", int'(life_change), 1);
        check("trunc_game_over", int'(game_over), 0);
        hit_in = 1'b0;
        idle(15);
        end_checks("after_restart");

        push_hit();
        hit_in = 1'b1;
        idle(20);
        hit_in = 1'b0;
        idle(20);
        end_checks("post_restart_hit");

        // Restart held across the hit event: restart wins.
        hit_in  = 1'b1;
        restart = 1'b1;
        idle(12);
        restart = 1'b0;
        m_lives = INIT;
        idle(5);
        hit_in = 1'b0;
        idle(15);
        end_checks("restart_wins");

        // Asynchronous reset mid-pulse, hit held through reset.
        push_hit();
        hit_in = 1'b1;
        wait_pulse("pulse_c_seen");
        idle(2);
        trunc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_life_change", int'(life_change), 1);
        check("async_rst_lives", int'(lives), INIT);
        check("async_rst_game_over", int'(game_over), 0);
        m_lives = INIT;
        idle(3);
        rst_n = 1'b1;
        push_hit();
        idle(25);
        hit_in = 1'b0;
        idle(15);
        end_checks("reset_held_hit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/life_tracker.md
LIFE_TRACKER -- requirements
Module: life_tracker

Interface
REQ-001 Parameter INIT_LIVES, default 3: lives loaded at reset and at restart; legal range 1..2^LIFE_W-1.
REQ-002 Parameter LIFE_W, default 3: width of the lives counter.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: clk cycles of stable input needed to accept a hit level (20 ms at 50 MHz).
REQ-004 Parameter PULSE_CYCLES, default 5000000: clk cycles that life_change is held low per hit (100 ms at 50 MHz).
REQ-005 clk  input  1  50 MHz system clock; all flops on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 hit_in  input  1  raw hit button/sensor, active-high, asynchronous to clk, may bounce.
REQ-008 restart  input  1  synchronous active-high level request to start a new game.
REQ-009 lives  output  LIFE_W  remaining lives, registered.
REQ-010 life_change  output  1  active-low notification pulse to the beeper stage, registered, glitch-free.
REQ-011 game_over  output  1  high while no lives remain, registered.

Function
REQ-012 hit_in shall pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: the filtered level shall change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match shall clear the debounce counter.
REQ-014 A hit event shall be a single-cycle 0->1 edge of the filtered level; a held input shall produce exactly one event.
REQ-015 FSM states: PLAY, PULSE, OVER.
REQ-016 PLAY + hit event: lives decrements by 1 on the next edge, life_change goes low on the same edge, pulse counter clears, state becomes PULSE.
REQ-017 PULSE: life_change shall stay low for exactly PULSE_CYCLES cycles, then return high.
REQ-018 PULSE end: the state becomes OVER if lives is 0, otherwise PLAY; game_over shall rise on the same edge that life_change returns high.
REQ-019 Hit events during PULSE or OVER shall be discarded, not queued.
REQ-020 lives shall never wrap below 0; a decrement at 0 is impossible because the FSM leaves PLAY.
REQ-021 restart in any state: lives=INIT_LIVES, life_change=1, game_over=0, pulse counter=0, state=PLAY on the next edge; any pulse in progress is truncated.
REQ-022 restart and hit event in the same cycle: restart wins and the hit is discarded.
REQ-023 The debounce path shall keep running in all states so that edge detection stays consistent after restart.
REQ-024 Counters shall be sized to hold their parameter values without overflow.

Reset
REQ-025 While rst_n=0: lives=INIT_LIVES, life_change=1, game_over=0, state=PLAY, synchronizer, filtered level and all counters 0.
REQ-026 Reset asserted mid-PULSE shall drive life_change high immediately, without waiting for clk.
REQ-027 After rst_n deasserts, a hit_in already held high shall produce one hit event once the debounce time has elapsed.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=8, INIT_LIVES=3)
REQ-028 Clean hit held 20 cycles -> exactly one event; lives 3->2; life_change low for exactly 8 cycles; game_over=0.
REQ-029 hit_in toggling every 2 cycles for 30 cycles, then low -> no event; lives stays 3; life_change stays 1.
REQ-030 Three separated hits -> lives 2,1,0; after the third pulse game_over=1 on the edge life_change rises; a fourth hit -> no change.
REQ-031 Second hit during a pulse -> ignored; lives decrements once only; pulse length stays 8.
REQ-032 restart asserted in cycle 3 of a pulse (lives=1) -> next edge: lives=3, life_change=1, game_over=0; a following hit behaves as in REQ-028.
REQ-033 rst_n pulled low asynchronously mid-pulse -> life_change=1 and lives=3 before the next clk edge.
